// File: rtl/breakout_pkg.sv
// Shared types and constants for the PS/2 keyboard front end: frame FSM states,
// HID keycodes produced for the game logic, and the set-2 prefix bytes.
package breakout_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] KC_NONE  = 8'h00;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_SPACE = 8'h2C;
  localparam logic [7:0] KC_ENTER = 8'h28;
  localparam logic [7:0] KC_ESC   = 8'h29;
  localparam logic [7:0] KC_LEFT  = 8'h50;
  localparam logic [7:0] KC_RIGHT = 8'h4F;
  localparam logic [7:0] KC_UP    = 8'h52;
  localparam logic [7:0] KC_DOWN  = 8'h51;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the pins, detects ps2_clk falls, and
// deserialises start/8 data/odd parity/stop frames with a mid-frame timeout.
module ps2_rx_frame
  import breakout_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_rdy,
  output logic       frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic            clk_p0, clk_p1, clk_p2;
  logic            data_p0, data_p1;
  logic            fall;
  ps2_state_t      state;
  logic [2:0]      bit_cnt;
  logic            par;
  logic [TO_W-1:0] to_cnt;

  assign fall = clk_p2 & ~clk_p1;

  // stage p0/p1: two-flop synchronisers; p2 holds the previous synced clock
  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_p0    <= 1'b1;
      clk_p1    <= 1'b1;
      clk_p2    <= 1'b1;
      data_p0   <= 1'b1;
      data_p1   <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      par       <= 1'b0;
      to_cnt    <= '0;
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      clk_p0    <= ps2_clk;
      clk_p1    <= clk_p0;
      clk_p2    <= clk_p1;
      data_p0   <= ps2_data;
      data_p1   <= data_p0;
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!data_p1) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
              par     <= 1'b0;
            end
          end
          DATA: begin
            par     <= par ^ data_p1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= par ^ data_p1;
            state <= STOP;
          end
          STOP: begin
            // par holds the XOR of data+parity bits; 1 means odd parity
            if (data_p1 && par) byte_rdy  <= 1'b1;
            else                frame_err <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == TO_LAST) begin
          frame_err <= 1'b1;
          state     <= IDLE;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (fall && state == DATA) rx_byte <= {data_p1, rx_byte[7:1]};
  end

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 keyboard front end: tracks E0/F0 prefixes, maps set-2 scan codes to HID
// codes, and holds the most recently made key until that key is released.
module ps2_keycode
  import breakout_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TIMEOUT_CYC = CLK_HZ / 1000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       byte_rdy;
  logic       ext;
  logic       brk;
  logic [7:0] hid;

  function automatic logic [7:0] map_hid(input logic is_ext, input logic [7:0] sc);
    logic [7:0] code;
    case ({is_ext, sc})
      9'h01C:  code = KC_A;
      9'h023:  code = KC_D;
      9'h01B:  code = KC_S;
      9'h01D:  code = KC_W;
      9'h029:  code = KC_SPACE;
      9'h05A:  code = KC_ENTER;
      9'h076:  code = KC_ESC;
      9'h16B:  code = KC_LEFT;
      9'h174:  code = KC_RIGHT;
      9'h175:  code = KC_UP;
      9'h172:  code = KC_DOWN;
      default: code = KC_NONE;
    endcase
    return code;
  endfunction

  ps2_rx_frame #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .Clk      (Clk),
    .Reset    (Reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .byte_rdy (byte_rdy),
    .frame_err(frame_err)
  );

  assign hid = map_hid(ext, rx_byte);

  // decode stage: one cycle after byte_rdy the held code and pulse settle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      keycode   <= KC_NONE;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (byte_rdy) begin
        if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          // releasing a key other than the held one leaves keycode alone
          if (!brk) begin
            if (hid != KC_NONE && hid != keycode) begin
              keycode   <= hid;
              key_valid <= 1'b1;
            end
          end else if (hid == keycode && keycode != KC_NONE) begin
            keycode   <= KC_NONE;
            key_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule
